// File: rtl/state_sequencer_pkg.sv
// Shared state encodings and opcode constants for the multicycle MIPS control path.
// The output decoder imports the same definitions.
package state_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_AEXE = 3'b110,
        S_BEXE = 3'b101,
        S_CEXE = 3'b010,
        S_MEM  = 3'b011,
        S_AWB  = 3'b111,
        S_CWB  = 3'b100
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/state_sequencer_sat_counter.sv
// Saturating up-counter with asynchronous reset; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + ONE;
        end
    end

    assign q = count_q;

endmodule

// File: rtl/state_sequencer.sv
// Control state register and next-state logic of the multicycle CPU, with
// halt/illegal flags and saturating cycle/retired-instruction counters.
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [5:0]       illegal_op,
    output logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    state_t     state_q, state_d;
    logic       halted_q, halted_d;
    logic       illegal_q, illegal_d;
    logic [5:0] illegal_op_q, illegal_op_d;
    logic       retire_q, retire_d;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IF;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            illegal_op_q <= 6'b0;
            retire_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            halted_q     <= halted_d;
            illegal_q    <= illegal_d;
            illegal_op_q <= illegal_op_d;
            retire_q     <= retire_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        halted_d     = halted_q;
        illegal_d    = illegal_q;
        illegal_op_d = illegal_op_q;
        retire_d     = 1'b0;
        case (state_q)
            S_IF:   state_d = halted_q ? S_IF : S_ID;
            S_ID: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_OR: state_d = S_AEXE;
                    OP_BEQ:                state_d = S_BEXE;
                    OP_SW, OP_LW:          state_d = S_CEXE;
                    OP_J: begin
                        state_d  = S_IF;
                        retire_d = 1'b1;
                    end
                    OP_HALT: begin
                        state_d  = S_IF;
                        retire_d = 1'b1;
                        halted_d = 1'b1;
                    end
                    default: begin
                        // Unknown opcodes retire as a nop; only the first one is recorded.
                        state_d  = S_IF;
                        retire_d = 1'b1;
                        if (!illegal_q) begin
                            illegal_d    = 1'b1;
                            illegal_op_d = opcode;
                        end
                    end
                endcase
            end
            S_AEXE: state_d = S_AWB;
            S_AWB: begin
                state_d  = S_IF;
                retire_d = 1'b1;
            end
            S_BEXE: begin
                state_d  = S_IF;
                retire_d = 1'b1;
            end
            S_CEXE: state_d = S_MEM;
            S_MEM: begin
                if (opcode == OP_SW) begin
                    state_d  = S_IF;
                    retire_d = 1'b1;
                end else if (opcode == OP_LW) begin
                    state_d = S_CWB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_CWB: begin
                state_d  = S_IF;
                retire_d = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    // Retired count steps on the same edge that raises the retire pulse.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .CLK   (CLK),
        .Reset (Reset),
        .inc   (~halted_q),
        .q     (cycle_count)
    );

    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .CLK   (CLK),
        .Reset (Reset),
        .inc   (retire_d),
        .q     (instr_count)
    );

    assign state      = state_q;
    assign halted     = halted_q;
    assign illegal    = illegal_q;
    assign illegal_op = illegal_op_q;
    assign retire     = retire_q;

endmodule
